router_read_scheduler: RTL and testbench

- Read-side packet scheduler for the 1x3 router, clocked in the output (clk2) domain.
- Watches the three output-FIFO valid flags and grants exactly one channel at a time, round-robin.
- Drives that channel's read enable for one complete packet (header, payload, parity) and presents the bytes as a single serialized stream to one downstream sink.
- Replaces ad-hoc priority read-enable logic; guarantees packets are never interleaved and no channel is starved.

---
 rtl/router_read_scheduler_pkg.sv | 27 ++
 rtl/router_read_scheduler_rr_pick3.sv | 35 +++
 rtl/router_read_scheduler.sv | 153 +++++++++++++++
 tb/tb_router_read_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_read_scheduler_pkg.sv
// Shared definitions for the 1x3 router read side: channel count, header
// field positions and the read-scheduler state encoding.
package router_read_scheduler_pkg;

  localparam int NUM_CH       = 3;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_DEST_MSB = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    HWAIT = 2'd2,
    BODY  = 2'd3
  } state_t;

  // Channel index successor modulo NUM_CH.
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch >= 2'(NUM_CH - 1)) ? 2'd0 : ch + 2'd1;
  endfunction

  function automatic logic [1:0] hdr_dest(input logic [7:0] hdr);
    return hdr[HDR_DEST_MSB:HDR_DEST_LSB];
  endfunction

endpackage

// File: rtl/router_read_scheduler_rr_pick3.sv
// Combinational round-robin selector: first set request searching from ptr
// upward modulo 3.
module rr_pick3
  import router_read_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  output logic [1:0]        gnt_idx,
  output logic              any
);

  logic [1:0] c0, c1, c2;

  always_comb begin
    c0 = (ptr >= 2'(NUM_CH)) ? 2'd0 : ptr;
    c1 = next_ch(c0);
    c2 = next_ch(c1);
    gnt_idx = 2'd0;
    any     = 1'b0;
    // Lowest search offset is evaluated last so it wins.
    if (req[c2]) begin
      gnt_idx = c2;
      any     = 1'b1;
    end
    if (req[c1]) begin
      gnt_idx = c1;
      any     = 1'b1;
    end
    if (req[c0]) begin
      gnt_idx = c0;
      any     = 1'b1;
    end
  end

endmodule

// File: rtl/router_read_scheduler.sv
// Read-side packet scheduler: grants one output FIFO at a time round-robin
// and streams one whole packet (header, payload, parity) to a single sink.
module router_read_scheduler
  import router_read_scheduler_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              clk2,
  input  logic              reset,
  input  logic              packet_valid_o1,
  input  logic              packet_valid_o2,
  input  logic              packet_valid_o3,
  input  logic [DATA_W-1:0] packet_out0,
  input  logic [DATA_W-1:0] packet_out1,
  input  logic [DATA_W-1:0] packet_out2,
  input  logic              sink_ready_i,
  output logic              read_enable_0,
  output logic              read_enable_1,
  output logic              read_enable_2,
  output logic [DATA_W-1:0] pkt_data_o,
  output logic              pkt_valid_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic [1:0]        grant_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int            CNT_W   = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LEN_W:0]   REM_ONE = (LEN_W + 1)'(1);

  state_t            state;
  logic [1:0]        grant;
  logic [1:0]        rr_ptr;
  logic [LEN_W:0]    remaining;
  logic [CNT_W-1:0]  to_cnt;
  logic              vld_p1, sop_p1, eop_p1, err_p1;

  logic [NUM_CH-1:0] req;
  logic [1:0]        pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] data_sel;
  logic [LEN_W-1:0]  hdr_len;
  logic              valid_grant, reading, issue, timeout_tick, to_hit;

  assign req = {packet_valid_o3, packet_valid_o2, packet_valid_o1};

  rr_pick3 u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    case (grant)
      2'd1:    data_sel = packet_out1;
      2'd2:    data_sel = packet_out2;
      default: data_sel = packet_out0;
    endcase
  end

  assign hdr_len      = data_sel[HDR_LEN_LSB +: LEN_W];
  assign valid_grant  = req[grant];
  assign reading      = (state == HDR) || (state == BODY);
  // A pop is held off during reset so an abandoned packet loses no extra byte.
  assign issue        = reading && valid_grant && sink_ready_i && !reset;
  assign timeout_tick = reading && sink_ready_i && !valid_grant;
  assign to_hit       = timeout_tick && (to_cnt == TO_LAST);

  assign read_enable_0 = issue && (grant == 2'd0);
  assign read_enable_1 = issue && (grant == 2'd1);
  assign read_enable_2 = issue && (grant == 2'd2);

  // Stage p0 -> p1: read issue registered alongside its data-cycle flags
  always_ff @(posedge clk2) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 2'd0;
      rr_ptr    <= 2'd0;
      remaining <= '0;
      to_cnt    <= '0;
      vld_p1    <= 1'b0;
      sop_p1    <= 1'b0;
      eop_p1    <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      vld_p1 <= issue;
      sop_p1 <= issue && (state == HDR);
      eop_p1 <= issue && (state == BODY) && (remaining == REM_ONE);
      err_p1 <= 1'b0;

      if (issue) begin
        to_cnt <= '0;
      end else if (timeout_tick) begin
        to_cnt <= to_cnt + CNT_ONE;
      end

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (pick_any) begin
            grant <= pick_idx;
            state <= HDR;
          end
        end
        HDR: begin
          if (issue) begin
            state <= HWAIT;
          end else if (to_hit) begin
            err_p1 <= 1'b1;
            rr_ptr <= next_ch(grant);
            to_cnt <= '0;
            state  <= IDLE;
          end
        end
        HWAIT: begin
          // Payload bytes plus the trailing parity byte.
          remaining <= {1'b0, hdr_len} + REM_ONE;
          state     <= BODY;
        end
        BODY: begin
          if (issue) begin
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              rr_ptr <= next_ch(grant);
              state  <= IDLE;
            end
          end else if (to_hit) begin
            err_p1 <= 1'b1;
            rr_ptr <= next_ch(grant);
            to_cnt <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pkt_valid_o = vld_p1;
  assign pkt_data_o  = vld_p1 ? data_sel : '0;
  assign sop_o       = sop_p1;
  assign eop_o       = eop_p1;
  assign grant_o     = grant;
  assign busy_o      = (state != IDLE);
  assign err_o       = err_p1;

endmodule

// File: tb/tb_router_read_scheduler.sv
// Scoreboard bench for router_read_scheduler: FIFO models feed packets, a
// packet-level round-robin model predicts the serialized output stream.
module tb_router_read_scheduler;

  logic       clk2 = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] fv = 3'b000;
  logic [7:0] fout [3];
  logic       sink_ready_i = 1'b1;
  logic       read_enable_0, read_enable_1, read_enable_2;
  logic [7:0] pkt_data_o;
  logic       pkt_valid_o, sop_o, eop_o, busy_o, err_o;
  logic [1:0] grant_o;

  router_read_scheduler #(.DATA_W(8), .LEN_W(6), .TIMEOUT(16)) dut (
    .clk2            (clk2),
    .reset           (reset),
    .packet_valid_o1 (fv[0]),
    .packet_valid_o2 (fv[1]),
    .packet_valid_o3 (fv[2]),
    .packet_out0     (fout[0]),
    .packet_out1     (fout[1]),
    .packet_out2     (fout[2]),
    .sink_ready_i    (sink_ready_i),
    .read_enable_0   (read_enable_0),
    .read_enable_1   (read_enable_1),
    .read_enable_2   (read_enable_2),
    .pkt_data_o      (pkt_data_o),
    .pkt_valid_o     (pkt_valid_o),
    .sop_o           (sop_o),
    .eop_o           (eop_o),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  always #5 clk2 = ~clk2;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] ch;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] fq0[$], fq1[$], fq2[$];
  logic [7:0] pool[$];
  int         pkt_ch[$], pkt_start[$], pkt_len[$], pend[$];
  int         ptr_m = 0;
  int         rd_cnt [3];
  int         n_tests = 0, n_fail = 0, err_seen = 0;
  int         mode = 0;
  logic [2:0] re;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic fifo_push(input int ch, input logic [7:0] b);
    case (ch)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
    fv[ch] = 1'b1;
  endtask

  task automatic fifo_pop(input int ch);
    int sz;
    case (ch)
      0: sz = fq0.size();
      1: sz = fq1.size();
      default: sz = fq2.size();
    endcase
    n_tests++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL read_empty: channel %0d popped with 0 bytes, required a non-empty FIFO", ch);
    end else begin
      case (ch)
        0: begin fout[0] = fq0.pop_front(); fv[0] = (fq0.size() != 0); end
        1: begin fout[1] = fq1.pop_front(); fv[1] = (fq1.size() != 0); end
        default: begin fout[2] = fq2.pop_front(); fv[2] = (fq2.size() != 0); end
      endcase
      rd_cnt[ch]++;
    end
  endtask

  task automatic clear_all();
    fq0.delete(); fq1.delete(); fq2.delete();
    fv = 3'b000;
    exp_q.delete();
    pend.delete();
    ptr_m = 0;
  endtask

  // Packet = {len,dest} header, len payload bytes, XOR parity byte.
  task automatic load_pkt(input int ch, input int len, input logic [1:0] dest);
    logic [7:0] b, par;
    int id;
    id = pkt_ch.size();
    pkt_ch.push_back(ch);
    pkt_start.push_back(pool.size());
    pkt_len.push_back(len);
    b = {6'(len), dest};
    par = b;
    pool.push_back(b);
    fifo_push(ch, b);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      par ^= b;
      pool.push_back(b);
      fifo_push(ch, b);
    end
    pool.push_back(par);
    fifo_push(ch, par);
    pend.push_back(id);
  endtask

  // Round-robin over pending packets: oldest packet of the first channel found
  // from ptr_m upward wins, and the pointer moves past the winner.
  task automatic expect_all();
    int pick, id, c;
    while (pend.size() > 0) begin
      pick = -1;
      for (int off = 0; off < 3; off++) begin
        c = (ptr_m + off) % 3;
        for (int j = 0; j < pend.size(); j++)
          if (pick < 0 && pkt_ch[pend[j]] == c) pick = j;
      end
      id = pend[pick];
      pend.delete(pick);
      for (int b = 0; b < pkt_len[id] + 2; b++)
        exp_q.push_back('{pool[pkt_start[id] + b], (b == 0), (b == pkt_len[id] + 1),
                          2'(pkt_ch[id])});
      ptr_m = (pkt_ch[id] + 1) % 3;
    end
  endtask

  task automatic tick();
    case (mode)
      0: sink_ready_i = 1'b1;
      1: sink_ready_i = ~sink_ready_i;
      default: sink_ready_i = 1'($urandom_range(0, 1));
    endcase
    #4;
    re = {read_enable_2, read_enable_1, read_enable_0};
    n_tests++;
    if ($countones(re) > 1 || (re != 3'b000 && !sink_ready_i)) begin
      n_fail++;
      $display("FAIL enable_rule: enables %b sink_ready %b, required at most one and none when not ready",
               re, sink_ready_i);
    end
    @(posedge clk2);
    #1;
    for (int k = 0; k < 3; k++) if (re[k]) fifo_pop(k);
    @(negedge clk2);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o || pkt_valid_o) && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_drained_bytes_left"}, exp_q.size(), 0);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_valid"}, pkt_valid_o, 0);
    chk({name, "_sop_eop"}, {sop_o, eop_o}, 0);
    chk({name, "_data"}, pkt_data_o, 0);
    chk({name, "_grant"}, grant_o, 0);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_err"}, err_o, 0);
    chk({name, "_enables"}, {read_enable_2, read_enable_1, read_enable_0}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    @(posedge clk2);
    @(negedge clk2);
    reset = 1'b0;
  endtask

  // Monitor: every byte the DUT presents is checked against the scoreboard.
  always @(negedge clk2) begin
    if (err_o) err_seen++;
    if (pkt_valid_o) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got %h sop %b eop %b grant %0d, required no byte",
                 pkt_data_o, sop_o, eop_o, grant_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({pkt_data_o, sop_o, eop_o, grant_o} !== {mon_e.data, mon_e.sop, mon_e.eop, mon_e.ch}) begin
          n_fail++;
          $display("FAIL stream_byte: got data %h sop %b eop %b grant %0d, required data %h sop %b eop %b grant %0d",
                   pkt_data_o, sop_o, eop_o, grant_o, mon_e.data, mon_e.sop, mon_e.eop, mon_e.ch);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, err_base;
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      fout[k] = 8'h00;
      rd_cnt[k] = 0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk2);
    check_quiet("reset");
    reset = 1'b0;

    // Single len-3 packet on channel 0, then pointer must favour channel 1.
    base = rd_cnt[0];
    load_pkt(0, 3, 2'd0);
    expect_all();
    drain("single");
    chk("single_reads", rd_cnt[0] - base, 5);
    load_pkt(0, 1, 2'd2);
    load_pkt(1, 1, 2'd3);
    expect_all();
    drain("ptr_after_single");

    // All channels valid with len-0 packets: grants 0,1,2,0,1,2.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) load_pkt(c, 0, 2'(c));
    expect_all();
    drain("rr_len0");

    // Toggling sink readiness through a len-4 packet.
    mode = 1;
    load_pkt(0, 4, 2'd1);
    expect_all();
    drain("toggle_sink");
    mode = 0;

    // Long packet with competing channels.
    do_reset();
    base = rd_cnt[0];
    load_pkt(0, 32, 2'd1);
    load_pkt(1, 2, 2'd0);
    load_pkt(2, 2, 2'd0);
    expect_all();
    drain("len32");
    chk("len32_reads", rd_cnt[0] - base, 34);

    // Channel 1 runs dry after 2 of 8 payload bytes; channel 2 follows.
    do_reset();
    err_base = err_seen;
    base = rd_cnt[1];
    b = {6'd8, 2'd1};
    fifo_push(1, b);
    exp_q.push_back('{b, 1'b1, 1'b0, 2'd1});
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      fifo_push(1, b);
      exp_q.push_back('{b, 1'b0, 1'b0, 2'd1});
    end
    load_pkt(2, 3, 2'd2);
    ptr_m = 2;
    expect_all();
    drain("timeout");
    chk("timeout_reads", rd_cnt[1] - base, 3);
    chk("timeout_err_pulses", err_seen - err_base, 1);

    // Reset in the middle of a packet body.
    load_pkt(0, 20, 2'd0);
    expect_all();
    repeat (8) tick();
    chk("midpkt_busy", busy_o, 1);
    reset = 1'b1;
    @(posedge clk2);
    #1;
    check_quiet("midpkt_reset");
    clear_all();
    @(negedge clk2);
    reset = 1'b0;
    tick();
    chk("post_reset_idle_busy", busy_o, 0);

    // Randomised traffic with random sink back-pressure.
    for (int r = 0; r < 6; r++) begin
      mode = 2;
      for (int i = 0; i < int'($urandom_range(1, 5)); i++)
        load_pkt(int'($urandom_range(0, 2)), int'($urandom_range(0, 12)), 2'($urandom));
      expect_all();
      drain("random");
    end
    mode = 0;
    tick();
    chk("err_total", err_seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
